// File: rtl/iq_dump_decim.sv
// iq_dump_decim: integrate-and-dump decimator for the filtered baseband I/Q
// stream. The two rails share one sample counter and one control path, so
// I and Q stay aligned. Each rail sums SPS valid samples, shifts the sum
// arithmetically, clamps it to WO bits and holds the result until the next dump.

// Per-rail accumulator, shift and saturation stage.
module iq_dump_rail #(
  parameter int WI    = 16,
  parameter int WO    = 16,
  parameter int SPS   = 8,
  parameter int SHIFT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          take,
  input  logic          dump,
  input  logic [WI-1:0] sample,
  output logic [WO-1:0] out,
  output logic          sat
);
  // The headroom covers SPS full-scale samples, so the sum cannot wrap.
  localparam int AW = WI + $clog2(SPS);
  // This width can hold the shifted sum and also the output range.
  localparam int EW = (AW > WO) ? AW : WO;
  localparam logic signed [EW-1:0] OMAX = $signed({{(EW-WO+1){1'b0}}, {(WO-1){1'b1}}});
  localparam logic signed [EW-1:0] OMIN = $signed({{(EW-WO+1){1'b1}}, {(WO-1){1'b0}}});

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic signed [EW-1:0] ext;
  logic [WO-1:0]        clamped;

  // Running sum including the current sample. The shift floors the result
  // toward -inf, and out-of-range values are clamped.
  always_comb begin
    sum     = acc + $signed({{(AW-WI){sample[WI-1]}}, sample});
    shifted = sum >>> SHIFT;
    ext     = EW'(shifted);
    clamped = ext[WO-1:0];
    sat     = 1'b0;
    if (ext > OMAX) begin
      clamped = OMAX[WO-1:0];
      sat     = 1'b1;
    end else if (ext < OMIN) begin
      clamped = OMIN[WO-1:0];
      sat     = 1'b1;
    end
  end

  // The accumulator clears on a realign and on a dump, so the dump sample
  // belongs to the symbol that is being dumped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           acc <= '0;
    else if (clr || dump) acc <= '0;
    else if (take)        acc <= sum;
  end

  // Output register: it loads only on a dump and otherwise holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out <= '0;
    else if (dump) out <= clamped;
  end
endmodule

// Top level: shared sample counter, phase realignment and the two rails.
module iq_dump_decim #(
  parameter int WI    = 16,
  parameter int WO    = 16,
  parameter int SPS   = 8,
  parameter int SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WI-1:0]           i_in,
  input  logic [WI-1:0]           q_in,
  input  logic                    iq_in_val,
  input  logic [$clog2(SPS)-1:0]  phase,
  input  logic                    phase_load,
  output logic [WO-1:0]           i_out,
  output logic [WO-1:0]           q_out,
  output logic                    iq_out_val,
  output logic                    sat_flag
);
  localparam int CW     = $clog2(SPS);
  localparam int NR     = 2;
  localparam int STAGES = 1;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  logic [CW-1:0]          cnt;
  logic [CW-1:0]          load_val;
  logic                   take;
  logic                   dump;
  logic [NR-1:0][WI-1:0]  rail_in;
  logic [NR-1:0][WO-1:0]  rail_out;
  logic [NR-1:0]          rail_sat;
  logic [STAGES:0]        vld_pipe;

  // phase_load wins over a coincident sample, and also over a would-be dump.
  assign take     = iq_in_val && !phase_load;
  assign dump     = take && (cnt == LAST);
  // A phase value beyond the last slot is pinned to the last slot.
  assign load_val = ({1'b0, phase} > (CW+1)'(SPS - 1)) ? LAST : phase;
  assign rail_in  = {q_in, i_in};

  // Sample counter: it advances only on consumed samples and wraps at SPS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (phase_load) cnt <= load_val;
    else if (take)       cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  for (genvar r = 0; r < NR; r++) begin : g_rail
    iq_dump_rail #(.WI(WI), .WO(WO), .SPS(SPS), .SHIFT(SHIFT)) u_rail (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (phase_load),
      .take   (take),
      .dump   (dump),
      .sample (rail_in[r]),
      .out    (rail_out[r]),
      .sat    (rail_sat[r])
    );
  end

  // The output strobe follows the dump by one cycle and lines up with the output registers.
  assign vld_pipe[0] = dump;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Sticky saturation flag: it is set when either rail clamps on a dump, and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     sat_flag <= 1'b0;
    else if (dump && (|rail_sat))   sat_flag <= 1'b1;
  end

  assign i_out      = rail_out[0];
  assign q_out      = rail_out[1];
  assign iq_out_val = vld_pipe[STAGES];
endmodule

// File: tb/tb_iq_dump_decim.sv
// Directed bench for iq_dump_decim. The main instance uses SPS=8 and SHIFT=3.
// A second instance with SHIFT=0 shares the same stimulus and covers saturation.
module tb_iq_dump_decim;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] i_in = '0, q_in = '0;
  logic iq_in_val = 1'b0;
  logic [2:0] phase = '0;
  logic phase_load = 1'b0;
  logic signed [15:0] i_out, q_out, i_out_s, q_out_s;
  logic iq_out_val, sat_flag, iq_out_val_s, sat_flag_s;

  int errors = 0;
  int checks = 0;
  int pulses;

  always #5 clk = ~clk;

  iq_dump_decim #(.WI(16), .WO(16), .SPS(8), .SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_in(i_in), .q_in(q_in), .iq_in_val(iq_in_val),
    .phase(phase), .phase_load(phase_load), .i_out(i_out), .q_out(q_out),
    .iq_out_val(iq_out_val), .sat_flag(sat_flag));

  iq_dump_decim #(.WI(16), .WO(16), .SPS(8), .SHIFT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_in(i_in), .q_in(q_in), .iq_in_val(iq_in_val),
    .phase(phase), .phase_load(phase_load), .i_out(i_out_s), .q_out(q_out_s),
    .iq_out_val(iq_out_val_s), .sat_flag(sat_flag_s));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic tick(input logic v, input int i, input int q,
                      input logic pl = 1'b0, input int ph = 0);
    iq_in_val  = v;
    i_in       = i[15:0];
    q_in       = q[15:0];
    phase_load = pl;
    phase      = ph[2:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("rst_i", i_out, 0);
    chk("rst_q", q_out, 0);
    chk("rst_val", iq_out_val, 0);
    chk("rst_sat", sat_flag, 0);
    rst_n = 1'b1;

    // Constant input: expect a pulse after every 8th sample, nowhere else
    for (int k = 1; k <= 16; k++) begin
      tick(1, 1000, -1000);
      chk($sformatf("const_val_%0d", k), iq_out_val, (k % 8 == 0) ? 1 : 0);
      if (k == 8) begin
        chk("const_i", i_out, 1000);
        chk("const_q", q_out, -1000);
      end
      if (k == 9) chk("const_hold_i", i_out, 1000);
    end
    chk("const_sat", sat_flag, 0);

    // Floor rounding: a sum of -1 shifted by 3 gives -1, a sum of +1 gives 0
    for (int k = 0; k < 7; k++) tick(1, 0, 0);
    tick(1, -1, -1);
    chk("floor_neg_val", iq_out_val, 1);
    chk("floor_neg_i", i_out, -1);
    chk("floor_neg_q", q_out, -1);
    for (int k = 0; k < 7; k++) tick(1, 0, 0);
    tick(1, 1, 1);
    chk("floor_pos_val", iq_out_val, 1);
    chk("floor_pos_i", i_out, 0);
    chk("floor_pos_q", q_out, 0);

    // Phase load mid-symbol: the sample on the load cycle is discarded
    tick(1, 8, 8);
    tick(1, 8, 8);
    tick(1, 100, 100, 1, 5);
    chk("pl_no_out", iq_out_val, 0);
    tick(1, 8, 8);
    chk("pl_v1", iq_out_val, 0);
    tick(1, 8, 8);
    chk("pl_v2", iq_out_val, 0);
    tick(1, 8, 8);
    chk("pl_v3", iq_out_val, 1);
    chk("pl_i", i_out, 3);
    chk("pl_q", q_out, 3);
    for (int k = 1; k <= 8; k++) begin
      tick(1, 8, 8);
      if (k == 7) chk("pl_next_early", iq_out_val, 0);
    end
    chk("pl_next_val", iq_out_val, 1);
    chk("pl_next_i", i_out, 8);

    // Phase load on the would-be dump cycle suppresses the dump
    for (int k = 0; k < 7; k++) tick(1, 8, 8);
    tick(1, 8, 8, 1, 0);
    chk("pl_sup_val", iq_out_val, 0);
    chk("pl_sup_hold", i_out, 8);
    for (int k = 1; k <= 8; k++) begin
      tick(1, 16, 16);
      if (k == 7) chk("pl_sup_early", iq_out_val, 0);
    end
    chk("pl_sup_next_val", iq_out_val, 1);
    chk("pl_sup_next_i", i_out, 16);

    // Gapped valid: ramp 1..8 with junk on the idle cycles, sum 36 -> 4
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1, k, 0);
      if (k < 8) begin
        if (iq_out_val) pulses++;
        for (int g = 0; g < 3; g++) begin
          tick(0, 999, 999);
          if (iq_out_val) pulses++;
        end
      end
    end
    chk("gap_no_early", pulses, 0);
    chk("gap_val", iq_out_val, 1);
    chk("gap_i", i_out, 4);
    chk("gap_q", q_out, 0);
    tick(0, 999, 999);
    chk("gap_pulse_one", iq_out_val, 0);

    // Saturation with SHIFT=0: +128000 clamps high, -128000 clamps low
    for (int k = 0; k < 8; k++) tick(1, 16000, -16000);
    chk("sat_i", i_out_s, 32767);
    chk("sat_q", q_out_s, -32768);
    chk("sat_flag", sat_flag_s, 1);
    chk("sat_main_i", i_out, 16000);
    chk("sat_main_flag", sat_flag, 0);
    for (int k = 0; k < 8; k++) tick(1, 10, 10);
    chk("sat_after_i", i_out_s, 80);
    chk("sat_sticky", sat_flag_s, 1);

    // Reset after 5 samples: outputs clear at once, and the partial sum is lost
    for (int k = 0; k < 5; k++) tick(1, 500, 500);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_i", i_out, 0);
    chk("mid_rst_q", q_out, 0);
    chk("mid_rst_sat", sat_flag_s, 0);
    tick(0, 0, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1, 40, -40);
      if (k == 7) chk("post_rst_early", iq_out_val, 0);
    end
    chk("post_rst_val", iq_out_val, 1);
    chk("post_rst_i", i_out, 40);
    chk("post_rst_q", q_out, -40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
